systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM systolic multiply: operand fetch, skewed feed, drain, result readout.
// Optional sticky accumulator overflow flag is built when SYSTOLIC_OVF_DETECT_EN is defined.
module systolic_ctrl #(
    parameter int DIM        = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           abort_i,
    output logic                           a_rd_en_o,
    output logic                           b_rd_en_o,
    output logic [$clog2(DIM)-1:0]         a_rd_addr_o,
    output logic [$clog2(DIM)-1:0]         b_rd_addr_o,
    input  logic [DIM*DATA_WIDTH-1:0]      a_rd_data_i,
    input  logic [DIM*DATA_WIDTH-1:0]      b_rd_data_i,
    output logic [DIM*DATA_WIDTH-1:0]      left_o,
    output logic [DIM*DATA_WIDTH-1:0]      up_o,
    output logic                           array_clr_o,
    input  logic [DIM*DIM-1:0]             carry_i,
    output logic                           res_valid_o,
    output logic [$clog2(DIM)-1:0]         res_sel_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           overflow_o
);
    localparam int AW = $clog2(DIM);
    localparam int CW = $clog2(2 * DIM);
    localparam logic [AW-1:0] K_LAST = AW'(DIM - 1);
    localparam logic [CW-1:0] C_LAST = CW'(2 * DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READ, S_DONE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_k;
    logic [CW-1:0]   r_cnt;
    logic            r_rd_en;
    logic            r_ret;
    logic            r_clr;
    logic            r_res_valid;
    logic [AW-1:0]   r_res_sel;
    logic            r_done;
    logic            r_busy;
    logic            w_abort;
    logic            w_skew_zero;

    assign w_abort     = abort_i && (r_state != S_IDLE);
    assign w_skew_zero = rst_i || w_abort || (r_state == S_CLEAR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_cnt       <= '0;
            r_rd_en     <= 1'b0;
            r_ret       <= 1'b0;
            r_clr       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_sel   <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_abort) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_cnt       <= '0;
            r_rd_en     <= 1'b0;
            r_ret       <= 1'b0;
            r_clr       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_sel   <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Read data lands one cycle after the strobe.
            r_ret <= r_rd_en;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_CLEAR;
                        r_clr   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_k     <= '0;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_FEED;
                    r_clr   <= 1'b0;
                    r_rd_en <= 1'b1;
                end
                S_FEED: begin
                    if (r_k == K_LAST) begin
                        r_state <= S_DRAIN;
                        r_rd_en <= 1'b0;
                        r_k     <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == C_LAST) begin
                        r_state     <= S_READ;
                        r_res_valid <= 1'b1;
                        r_res_sel   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (r_res_sel == K_LAST) begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b0;
                        r_res_sel   <= '0;
                        r_done      <= 1'b1;
                    end else begin
                        r_res_sel <= r_res_sel + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Lane gi is a delay line of depth gi+1 so row/column gi enters the array gi cycles late.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_a_line [0:gi];
        logic [DATA_WIDTH-1:0] r_b_line [0:gi];

        always_ff @(posedge clk_i) begin
            if (w_skew_zero) begin
                for (int s = 0; s <= gi; s++) begin
                    r_a_line[s] <= '0;
                    r_b_line[s] <= '0;
                end
            end else begin
                r_a_line[0] <= r_ret ? a_rd_data_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                r_b_line[0] <= r_ret ? b_rd_data_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int s = 1; s <= gi; s++) begin
                    r_a_line[s] <= r_a_line[s-1];
                    r_b_line[s] <= r_b_line[s-1];
                end
            end
        end

        assign left_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_a_line[gi];
        assign up_o[gi*DATA_WIDTH +: DATA_WIDTH]   = r_b_line[gi];
    end

`ifdef SYSTOLIC_OVF_DETECT_EN
    logic r_ovf;

    always_ff @(posedge clk_i) begin
        if (rst_i || r_state == S_CLEAR) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_FEED || r_state == S_DRAIN || r_state == S_READ) && (|carry_i)) begin
            r_ovf <= 1'b1;
        end
    end

    assign overflow_o = r_ovf;
`else
    logic w_unused_carry;
    assign w_unused_carry = ^carry_i;
    assign overflow_o     = 1'b0;
`endif

    assign a_rd_en_o   = r_rd_en;
    assign b_rd_en_o   = r_rd_en;
    assign a_rd_addr_o = r_k;
    assign b_rd_addr_o = r_k;
    // Clear is forced combinationally so the array is held cleared for every cycle reset is high.
    assign array_clr_o = r_clr || rst_i;
    assign res_valid_o = r_res_valid;
    assign res_sel_o   = r_res_sel;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: operand buffers and a behavioural 4x4 PE array around the DUT.
module tb_systolic_ctrl;
    localparam int DIM = 4;
    localparam int DW  = 32;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                start_i = 1'b0;
    logic                abort_i = 1'b0;
    logic                a_rd_en_o, b_rd_en_o;
    logic [1:0]          a_rd_addr_o, b_rd_addr_o;
    logic [DIM*DW-1:0]   a_rd_data_i = '0;
    logic [DIM*DW-1:0]   b_rd_data_i = '0;
    logic [DIM*DW-1:0]   left_o, up_o;
    logic                array_clr_o;
    logic [DIM*DIM-1:0]  carry_i = '0;
    logic                res_valid_o;
    logic [1:0]          res_sel_o;
    logic                busy_o, done_o, overflow_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mat_a [4][4];
    logic [31:0] mat_b [4][4];
    logic [31:0] exp_c [4][4];
    logic        exp_ovf;

    logic [31:0] acc [4][4];
    logic [31:0] ah  [4][4];
    logic [31:0] bv  [4][4];
    logic [31:0] pa  [4][4];
    logic [31:0] pb  [4][4];
    logic [63:0] sum [4][4];

    systolic_ctrl #(.DIM(DIM), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .a_rd_en_o(a_rd_en_o), .b_rd_en_o(b_rd_en_o),
        .a_rd_addr_o(a_rd_addr_o), .b_rd_addr_o(b_rd_addr_o),
        .a_rd_data_i(a_rd_data_i), .b_rd_data_i(b_rd_data_i),
        .left_o(left_o), .up_o(up_o), .array_clr_o(array_clr_o),
        .carry_i(carry_i), .res_valid_o(res_valid_o), .res_sel_o(res_sel_o),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Operand buffers: one-cycle read latency, junk on the bus when not strobed.
    always @(posedge clk_i) begin
        for (int i = 0; i < DIM; i++) begin
            a_rd_data_i[i*DW +: DW] <= a_rd_en_o ? mat_a[i][a_rd_addr_o] : 32'hDEADBEEF;
            b_rd_data_i[i*DW +: DW] <= b_rd_en_o ? mat_b[b_rd_addr_o][i] : 32'hDEADBEEF;
        end
    end

    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                pa[i][j]  = (j == 0) ? left_o[i*DW +: DW] : ah[i][(j == 0) ? 0 : j - 1];
                pb[i][j]  = (i == 0) ? up_o[j*DW +: DW]   : bv[(i == 0) ? 0 : i - 1][j];
                sum[i][j] = {32'b0, acc[i][j]} + (64'(pa[i][j]) * 64'(pb[i][j]));
            end
        end
    end

    always @(posedge clk_i) begin
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                if (array_clr_o) begin
                    acc[i][j] <= '0;
                    ah[i][j]  <= '0;
                    bv[i][j]  <= '0;
                    carry_i[i*DIM+j] <= 1'b0;
                end else begin
                    acc[i][j] <= sum[i][j][31:0];
                    ah[i][j]  <= pa[i][j];
                    bv[i][j]  <= pb[i][j];
                    carry_i[i*DIM+j] <= |sum[i][j][63:32];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_mats(input logic [31:0] av, input logic [31:0] bvv, input logic [31:0] cv, input bit ident);
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                mat_a[i][j] = ident ? ((i == j) ? 32'd1 : 32'd0) : av;
                mat_b[i][j] = ident ? 32'(i*DIM + j + 1) : bvv;
                exp_c[i][j] = ident ? 32'(i*DIM + j + 1) : cv;
            end
        end
    endtask

    // Launch one operation from IDLE and follow it to completion.
    task automatic run_op(input string name, input bit hold, input int exp_l3);
        int first_feed = -1;
        int first_l3   = -1;
        int done_cyc   = -1;
        int rows = 0, clrs = 0, feeds = 0;
        start_i = 1'b1;
        step();
        if (!hold) start_i = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (array_clr_o) clrs++;
            if (a_rd_en_o) begin
                if (first_feed < 0) first_feed = cyc;
                chk({name, " a_rd_addr"}, 128'(a_rd_addr_o), 128'(feeds));
                chk({name, " b_rd_en"}, 128'(b_rd_en_o), 128'd1);
                chk({name, " b_rd_addr"}, 128'(b_rd_addr_o), 128'(feeds));
                feeds++;
            end
            if (first_l3 < 0 && left_o[127:96] != 32'd0) first_l3 = cyc;
            if (res_valid_o && rows < DIM) begin
                chk({name, " res_sel"}, 128'(res_sel_o), 128'(rows));
                for (int j = 0; j < DIM; j++)
                    chk($sformatf("%s C[%0d][%0d]", name, rows, j), 128'(acc[rows][j]), 128'(exp_c[rows][j]));
                rows++;
            end
            if (done_o) begin
                done_cyc = cyc;
                chk({name, " overflow@done"}, 128'(overflow_o), 128'(exp_ovf));
                break;
            end
            step();
        end
        chk({name, " done latency"}, 128'(done_cyc), 128'd18);
        chk({name, " first feed"}, 128'(first_feed), 128'd2);
        chk({name, " left lane3 first"}, 128'(first_l3 - first_feed), 128'(exp_l3));
        chk({name, " rows read"}, 128'(rows), 128'd4);
        chk({name, " clear cycles"}, 128'(clrs), 128'd1);
        chk({name, " feed cycles"}, 128'(feeds), 128'd4);
        step();
        chk({name, " idle busy"}, 128'(busy_o), 128'd0);
        chk({name, " idle done"}, 128'(done_o), 128'd0);
        chk({name, " idle overflow"}, 128'(overflow_o), 128'(exp_ovf));
        $display("op %s: done after %0d cycles, %0d rows read", name, done_cyc, rows);
    endtask

    initial begin
        int dones;
        int nz;
        exp_ovf = 1'b0;
        set_mats('0, '0, '0, 1'b1);

        // Reset
        step();
        step();
        chk("rst clr", 128'(array_clr_o), 128'd1);
        chk("rst busy", 128'(busy_o), 128'd0);
        chk("rst done", 128'(done_o), 128'd0);
        chk("rst rd_en", 128'(a_rd_en_o), 128'd0);
        chk("rst left", left_o, 128'd0);
        chk("rst up", up_o, 128'd0);
        chk("rst res_valid", 128'(res_valid_o), 128'd0);
        chk("rst ovf", 128'(overflow_o), 128'd0);
        rst_i = 1'b0;
        step();
        chk("post-rst clr", 128'(array_clr_o), 128'd0);
        $display("reset released");

        run_op("ident", 1'b0, 8);

        set_mats(32'd2, 32'd3, 32'd24, 1'b0);
        run_op("twos_threes", 1'b0, 5);

        // Start held across the whole run, then a second op begins from IDLE
        run_op("held_start", 1'b1, 5);
        step();
        chk("held 2nd clr", 128'(array_clr_o), 128'd1);
        chk("held 2nd busy", 128'(busy_o), 128'd1);
        start_i = 1'b0;
        step();
        chk("abort feed1 addr", 128'(a_rd_addr_o), 128'd0);
        step();
        chk("abort feed2 rd_en", 128'(a_rd_en_o), 128'd1);
        chk("abort feed2 addr", 128'(a_rd_addr_o), 128'd1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort busy", 128'(busy_o), 128'd0);
        chk("abort rd_en", 128'(a_rd_en_o), 128'd0);
        chk("abort left", left_o, 128'd0);
        chk("abort up", up_o, 128'd0);
        chk("abort res_valid", 128'(res_valid_o), 128'd0);
        dones = 0;
        nz = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_o) dones++;
            if (left_o != '0 || up_o != '0) nz++;
            step();
        end
        chk("abort no done", 128'(dones), 128'd0);
        chk("abort lanes stay 0", 128'(nz), 128'd0);
        $display("abort in FEED cycle 2 handled");

        set_mats('0, '0, '0, 1'b1);
        run_op("after_abort", 1'b0, 8);

        // Reset while draining
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("drain busy", 128'(busy_o), 128'd1);
        chk("drain rd_en", 128'(a_rd_en_o), 128'd0);
        rst_i = 1'b1;
        #1;
        chk("drain rst clr", 128'(array_clr_o), 128'd1);
        step();
        chk("drain rst busy", 128'(busy_o), 128'd0);
        chk("drain rst left", left_o, 128'd0);
        chk("drain rst up", up_o, 128'd0);
        chk("drain rst res_sel", 128'(res_sel_o), 128'd0);
        chk("drain rst addr", 128'(a_rd_addr_o), 128'd0);
        chk("drain rst clr2", 128'(array_clr_o), 128'd1);
        rst_i = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done_o) dones++;
        end
        chk("drain rst no done", 128'(dones), 128'd0);
        $display("reset during DRAIN handled");

        // All-ones operands: every product carries out of 32 bits
`ifdef SYSTOLIC_OVF_DETECT_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        set_mats(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 1'b0);
        run_op("all_ones", 1'b0, 5);
        step();
        chk("ovf held idle", 128'(overflow_o), 128'(exp_ovf));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
